// File: rtl/gyro_pkg.sv
// Shared definitions for the gyro square-wave demodulator: FSM encoding and
// saturation limits for a signed accumulator of a given width.
package gyro_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSkipH = 3'd1,
    StAccH  = 3'd2,
    StSkipL = 3'd3,
    StAccL  = 3'd4
  } state_e;

  localparam int unsigned CNT_BIT = 16;

  // Limits are returned in 64 bits; callers truncate to their accumulator width.
  function automatic logic [63:0] sat_max(input int unsigned width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int unsigned width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/gyro_sat_acc.sv
// Signed saturating accumulator: clear, enable and a sign-extended sample input.
// Clear and enable together load the sample into an empty accumulator.
module gyro_sat_acc
  import gyro_pkg::*;
#(
  parameter int unsigned ADC_BIT = 14,
  parameter int unsigned ACC_BIT = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic [ADC_BIT-1:0] i_sample,
  output logic [ACC_BIT-1:0] o_acc
);

  localparam logic [ACC_BIT-1:0] ACC_MAX = ACC_BIT'(sat_max(ACC_BIT));
  localparam logic [ACC_BIT-1:0] ACC_MIN = ACC_BIT'(sat_min(ACC_BIT));

  logic [ACC_BIT-1:0] acc_q, acc_d, base;
  logic [ACC_BIT:0]   sum;

  always_comb begin
    base  = i_clr ? '0 : acc_q;
    sum   = {base[ACC_BIT-1], base}
          + {{(ACC_BIT + 1 - ADC_BIT){i_sample[ADC_BIT-1]}}, i_sample};
    acc_d = base;
    if (i_en) begin
      // Top two bits disagree only on overflow; clamp toward the true sign.
      if (sum[ACC_BIT] != sum[ACC_BIT-1]) begin
        acc_d = sum[ACC_BIT] ? ACC_MIN : ACC_MAX;
      end else begin
        acc_d = sum[ACC_BIT-1:0];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign o_acc = acc_q;

endmodule

// File: rtl/gyro_demod.sv
// Square-wave demodulator: per modulation period, sums settled samples of the HIGH
// and LOW phases and emits their saturated signed difference.
module gyro_demod
  import gyro_pkg::*;
#(
  parameter int unsigned ADC_BIT = 14,
  parameter int unsigned ACC_BIT = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_status,
  input  logic [ADC_BIT-1:0] i_adc_data,
  input  logic [15:0]        i_skip,
  input  logic [15:0]        i_win,
  input  logic               i_polarity,
  output logic [ACC_BIT-1:0] o_err,
  output logic               o_err_valid,
  output logic               o_short,
  output logic [2:0]         o_state
);

  localparam logic [ACC_BIT-1:0] ACC_MAX = ACC_BIT'(sat_max(ACC_BIT));
  localparam logic [ACC_BIT-1:0] ACC_MIN = ACC_BIT'(sat_min(ACC_BIT));

  state_e               state_q, state_d;
  logic                 status_q;
  logic [CNT_BIT-1:0]   pcnt_q, pcnt_d, acnt_q, acnt_d;
  logic [CNT_BIT-1:0]   skip_q, win_q;
  logic                 pol_q;
  logic                 short_h_q, short_h_d;
  logic [ACC_BIT-1:0]   err_q, err_d;
  logic                 err_valid_q, err_valid_d;
  logic                 short_q, short_d;

  logic                 rise, fall;
  logic                 phase_h, phase_l, start_h, start_l, finish, in_h, in_l, take;
  logic [CNT_BIT-1:0]   idx, acnt_cur, cur_skip, cur_win;
  logic [ACC_BIT-1:0]   acc_h, acc_l, diff_sat;
  logic [ACC_BIT:0]     diff;

  assign rise = i_status & ~status_q;
  assign fall = ~i_status & status_q;

  always_comb begin
    if (pol_q) begin
      diff = {acc_l[ACC_BIT-1], acc_l} - {acc_h[ACC_BIT-1], acc_h};
    end else begin
      diff = {acc_h[ACC_BIT-1], acc_h} - {acc_l[ACC_BIT-1], acc_l};
    end
    if (diff[ACC_BIT] != diff[ACC_BIT-1]) begin
      diff_sat = diff[ACC_BIT] ? ACC_MIN : ACC_MAX;
    end else begin
      diff_sat = diff[ACC_BIT-1:0];
    end
  end

  always_comb begin
    phase_h  = (state_q == StSkipH) || (state_q == StAccH);
    phase_l  = (state_q == StSkipL) || (state_q == StAccL);
    start_h  = rise && ((state_q == StIdle) || phase_l);
    start_l  = fall && phase_h;
    finish   = rise && phase_l;
    in_h     = start_h || (phase_h && !start_l);
    in_l     = start_l || (phase_l && !start_h);
    // The edge cycle already runs under the configuration being latched.
    cur_skip = start_h ? i_skip : skip_q;
    cur_win  = start_h ? i_win : win_q;
    idx      = (start_h || start_l) ? '0 : pcnt_q;
    acnt_cur = (start_h || start_l) ? '0 : acnt_q;
    take     = (in_h || in_l) && (idx >= cur_skip) && (acnt_cur < cur_win);

    state_d     = state_q;
    pcnt_d      = pcnt_q;
    acnt_d      = acnt_q;
    short_h_d   = short_h_q;
    err_d       = err_q;
    err_valid_d = 1'b0;
    short_d     = short_q;

    if (in_h || in_l) begin
      pcnt_d = (idx == '1) ? idx : idx + 16'd1;
      acnt_d = acnt_cur + {15'd0, take};
      if (({1'b0, idx} + 17'd1) >= {1'b0, cur_skip}) begin
        state_d = in_h ? StAccH : StAccL;
      end else begin
        state_d = in_h ? StSkipH : StSkipL;
      end
    end

    if (start_l) begin
      short_h_d = acnt_q < win_q;
    end

    if (finish) begin
      err_d       = diff_sat;
      err_valid_d = 1'b1;
      short_d     = short_h_q | (acnt_q < win_q);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      status_q    <= 1'b0;
      pcnt_q      <= '0;
      acnt_q      <= '0;
      skip_q      <= '0;
      win_q       <= '0;
      pol_q       <= 1'b0;
      short_h_q   <= 1'b0;
      err_q       <= '0;
      err_valid_q <= 1'b0;
      short_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      status_q    <= i_status;
      pcnt_q      <= pcnt_d;
      acnt_q      <= acnt_d;
      short_h_q   <= short_h_d;
      err_q       <= err_d;
      err_valid_q <= err_valid_d;
      short_q     <= short_d;
      if (rise) begin
        skip_q <= i_skip;
        win_q  <= i_win;
        pol_q  <= i_polarity;
      end
    end
  end

  gyro_sat_acc #(
    .ADC_BIT (ADC_BIT),
    .ACC_BIT (ACC_BIT)
  ) u_acc_h (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (start_h),
    .i_en     (take && in_h),
    .i_sample (i_adc_data),
    .o_acc    (acc_h)
  );

  gyro_sat_acc #(
    .ADC_BIT (ADC_BIT),
    .ACC_BIT (ACC_BIT)
  ) u_acc_l (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (start_l),
    .i_en     (take && in_l),
    .i_sample (i_adc_data),
    .o_acc    (acc_l)
  );

  assign o_err       = err_q;
  assign o_err_valid = err_valid_q;
  assign o_short     = short_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_gyro_demod.sv
// Directed bench for gyro_demod: a 32-bit instance and a 16-bit instance share stimulus
// so accumulator and output saturation can be observed alongside the wide result.
module tb_gyro_demod;

  logic               clk;
  logic               i_rst_n;
  logic               i_status;
  logic [13:0]        i_adc_data;
  logic [15:0]        i_skip;
  logic [15:0]        i_win;
  logic               i_polarity;
  logic signed [31:0] o_err;
  logic               o_err_valid;
  logic               o_short;
  logic [2:0]         o_state;
  logic signed [15:0] s_err;
  logic               s_err_valid;
  logic               s_short;
  logic [2:0]         s_state;

  int                 n_cmp;
  int                 n_fail;
  int                 vcount;
  logic signed [31:0] verr;
  logic               vshort;
  logic signed [15:0] serr_cap;
  logic               sshort_cap;

  gyro_demod dut (
    .i_clk       (clk),
    .i_rst_n     (i_rst_n),
    .i_status    (i_status),
    .i_adc_data  (i_adc_data),
    .i_skip      (i_skip),
    .i_win       (i_win),
    .i_polarity  (i_polarity),
    .o_err       (o_err),
    .o_err_valid (o_err_valid),
    .o_short     (o_short),
    .o_state     (o_state)
  );

  gyro_demod #(
    .ADC_BIT (14),
    .ACC_BIT (16)
  ) dut_s (
    .i_clk       (clk),
    .i_rst_n     (i_rst_n),
    .i_status    (i_status),
    .i_adc_data  (i_adc_data),
    .i_skip      (i_skip),
    .i_win       (i_win),
    .i_polarity  (i_polarity),
    .o_err       (s_err),
    .o_err_valid (s_err_valid),
    .o_short     (s_short),
    .o_state     (s_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture each result pulse away from the active edge.
  always @(negedge clk) begin
    if (o_err_valid) begin
      vcount <= vcount + 1;
      verr   <= o_err;
      vshort <= o_short;
    end
    if (s_err_valid) begin
      serr_cap   <= s_err;
      sshort_cap <= s_short;
    end
  end

  task automatic drive(input logic st, input int val, input int n);
    for (int k = 0; k < n; k++) begin
      i_status   = st;
      i_adc_data = 14'(val);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_period(input int hl, input int ll, input int h0, input int hv,
                            input int l0, input int lv);
    drive(1'b1, h0, 1);
    drive(1'b1, hv, hl - 1);
    drive(1'b0, l0, 1);
    drive(1'b0, lv, ll - 1);
  endtask

  task automatic set_cfg(input int skip, input int win, input logic pol);
    i_skip     = 16'(skip);
    i_win      = 16'(win);
    i_polarity = pol;
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (o_err !== 32'sd0 || o_err_valid !== 1'b0 || o_short !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got err=%0d valid=%b short=%b want 0/0/0",
               o_err, o_err_valid, o_short);
    end
    n_cmp++;
    if (o_state !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d want 0", o_state);
    end
    i_rst_n = 1'b1;
    drive(1'b0, 0, 3);
  endtask

  task automatic test_basic;
    set_cfg(2, 4, 1'b0);
    run_period(8, 8, 100, 100, -100, -100);
    n_cmp++;
    if (vcount !== 0) begin
      n_fail++;
      $display("FAIL basic_first_period_silent: got %0d pulses want 0", vcount);
    end
    drive(1'b1, 100, 1);
    n_cmp++;
    if (o_err_valid !== 1'b1 || o_err !== 32'sd800 || o_short !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: got valid=%b err=%0d short=%b want 1/800/0",
               o_err_valid, o_err, o_short);
    end
    drive(1'b1, 100, 1);
    n_cmp++;
    if (o_err_valid !== 1'b0 || o_err !== 32'sd800) begin
      n_fail++;
      $display("FAIL basic_hold: got valid=%b err=%0d want 0/800", o_err_valid, o_err);
    end
    drive(1'b1, 100, 6);
    i_polarity = 1'b1;
    drive(1'b0, -100, 8);
  endtask

  task automatic test_polarity;
    run_period(8, 8, 100, 100, -100, -100);
    n_cmp++;
    if (verr !== 32'sd800) begin
      n_fail++;
      $display("FAIL pol_midperiod_ignored: got %0d want 800", verr);
    end
    run_period(8, 8, 100, 100, -100, -100);
    n_cmp++;
    if (verr !== -32'sd800) begin
      n_fail++;
      $display("FAIL pol_inverted: got %0d want -800", verr);
    end
    i_polarity = 1'b0;
    run_period(8, 8, 100, 100, -100, -100);
    n_cmp++;
    if (verr !== -32'sd800 || vcount !== 4) begin
      n_fail++;
      $display("FAIL pol_latched: got err=%0d pulses=%0d want -800/4", verr, vcount);
    end
  endtask

  task automatic test_short;
    set_cfg(6, 4, 1'b0);
    run_period(8, 8, 100, 100, -100, -100);
    run_period(8, 8, 100, 100, -100, -100);
    n_cmp++;
    if (verr !== 32'sd400 || vshort !== 1'b1) begin
      n_fail++;
      $display("FAIL short_phase: got err=%0d short=%b want 400/1", verr, vshort);
    end
  endtask

  task automatic test_skip_zero;
    set_cfg(0, 4, 1'b0);
    run_period(8, 8, 1000, 100, -1000, -100);
    run_period(8, 8, 100, 100, -100, -100);
    n_cmp++;
    if (verr !== 32'sd2600 || vshort !== 1'b0) begin
      n_fail++;
      $display("FAIL skip_zero_edge_sample: got err=%0d short=%b want 2600/0", verr, vshort);
    end
  endtask

  task automatic test_win_zero;
    int vc;
    set_cfg(2, 0, 1'b0);
    vc = vcount;
    run_period(8, 8, 100, 100, -100, -100);
    run_period(8, 8, 100, 100, -100, -100);
    n_cmp++;
    if (verr !== 32'sd0 || vshort !== 1'b0 || vcount !== vc + 2) begin
      n_fail++;
      $display("FAIL win_zero: got err=%0d short=%b pulses=%0d want 0/0/%0d",
               verr, vshort, vcount - vc, 2);
    end
  endtask

  task automatic test_unequal;
    int vc;
    set_cfg(2, 4, 1'b0);
    run_period(8, 9, 100, 100, -100, -100);
    run_period(8, 9, 100, 100, -100, -100);
    n_cmp++;
    if (verr !== 32'sd800 || vshort !== 1'b0) begin
      n_fail++;
      $display("FAIL unequal_first: got err=%0d short=%b want 800/0", verr, vshort);
    end
    vc = vcount;
    run_period(8, 9, 100, 100, -100, -100);
    n_cmp++;
    if (verr !== 32'sd800 || vcount !== vc + 1) begin
      n_fail++;
      $display("FAIL unequal_second: got err=%0d pulses=%0d want 800/1", verr, vcount - vc);
    end
  endtask

  task automatic test_saturation;
    set_cfg(0, 8, 1'b0);
    run_period(8, 8, 8191, 8191, -8192, -8192);
    run_period(8, 8, 8191, 8191, -8192, -8192);
    n_cmp++;
    if (serr_cap !== 16'sd32767 || sshort_cap !== 1'b0) begin
      n_fail++;
      $display("FAIL sat16_pos: got err=%0d short=%b want 32767/0", serr_cap, sshort_cap);
    end
    n_cmp++;
    if (verr !== 32'sd131064) begin
      n_fail++;
      $display("FAIL sat32_pos: got %0d want 131064", verr);
    end
    i_polarity = 1'b1;
    run_period(8, 8, 8191, 8191, -8192, -8192);
    run_period(8, 8, 8191, 8191, -8192, -8192);
    n_cmp++;
    if (serr_cap !== -16'sd32768) begin
      n_fail++;
      $display("FAIL sat16_neg: got %0d want -32768", serr_cap);
    end
    n_cmp++;
    if (verr !== -32'sd131064) begin
      n_fail++;
      $display("FAIL sat32_neg: got %0d want -131064", verr);
    end
  endtask

  task automatic test_reset_mid;
    int vc;
    set_cfg(2, 4, 1'b0);
    run_period(8, 8, 100, 100, -100, -100);
    drive(1'b1, 100, 8);
    drive(1'b0, -100, 5);
    n_cmp++;
    if (o_state !== 3'd4 || o_err !== 32'sd800) begin
      n_fail++;
      $display("FAIL pre_reset: got state=%0d err=%0d want 4/800", o_state, o_err);
    end
    i_rst_n = 1'b0;
    #1;
    n_cmp++;
    if (o_err !== 32'sd0 || o_err_valid !== 1'b0 || o_short !== 1'b0 || o_state !== 3'd0 ||
        s_err !== 16'sd0 || s_state !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got err=%0d valid=%b short=%b state=%0d s_err=%0d want zeros",
               o_err, o_err_valid, o_short, o_state, s_err);
    end
    @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    drive(1'b0, -100, 3);
    vc = vcount;
    run_period(8, 8, 100, 100, -100, -100);
    n_cmp++;
    if (vcount !== vc) begin
      n_fail++;
      $display("FAIL post_reset_silent: got %0d pulses want 0", vcount - vc);
    end
    run_period(8, 8, 100, 100, -100, -100);
    n_cmp++;
    if (vcount !== vc + 1 || verr !== 32'sd800) begin
      n_fail++;
      $display("FAIL post_reset_first: got pulses=%0d err=%0d want 1/800", vcount - vc, verr);
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    vcount     = 0;
    verr       = '0;
    vshort     = 1'b0;
    serr_cap   = '0;
    sshort_cap = 1'b0;
    i_rst_n    = 1'b0;
    i_status   = 1'b0;
    i_adc_data = '0;
    set_cfg(0, 0, 1'b0);
    test_reset();
    test_basic();
    test_polarity();
    test_short();
    test_skip_zero();
    test_win_zero();
    test_unequal();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
